// File: rtl/accel_pwm_decoder_if.sv
// Signal bundle between the accelerometer PWM pins and the decoded acceleration words.
// The decoder takes the slave side; the sensor/bench side drives pwm as master.
interface accel_pwm_decoder_if;
  logic       pwm_x;
  logic       pwm_y;
  logic [8:0] accelX;
  logic [8:0] accelY;
  logic       valid_x;
  logic       valid_y;
  logic       fault_x;
  logic       fault_y;

  modport master (
    output pwm_x, pwm_y,
    input  accelX, accelY, valid_x, valid_y, fault_x, fault_y
  );

  modport slave (
    input  pwm_x, pwm_y,
    output accelX, accelY, valid_x, valid_y, fault_x, fault_y
  );
endinterface

// File: rtl/accel_pwm_decoder.sv
// Dual-axis PWM duty-cycle decoder: measures each pulse's high time in PRESCALE-cycle
// counts, saturates to 9 bits, strobes valid, and flags a timeout on a dead/stuck sensor.
module accel_pwm_decoder #(
  parameter int         PRESCALE       = 977,
  parameter int         TIMEOUT_CYCLES = 1500000,
  parameter logic [8:0] LEVEL          = 9'h100
) (
  input logic           clk,
  input logic           reset,
  accel_pwm_decoder_if.slave bus
);

  localparam int              PW       = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0]   PRE_TOP  = PW'(PRESCALE);
  localparam logic [20:0]     TO_LAST  = 21'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ARM       = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] HIGH      = 2'd2;

  logic [1:0] pwm_raw;
  assign pwm_raw = {bus.pwm_y, bus.pwm_x};

  for (genvar g = 0; g < 2; g++) begin : g_axis
    logic          sync1;
    logic          s;
    logic          s_d;
    logic [1:0]    state;
    logic [1:0]    warm;
    logic [PW-1:0] presc;
    logic [8:0]    ticks;
    logic [20:0]   tcnt;
    logic [8:0]    accel;
    logic          valid;
    logic          fault;

    logic          rise;
    logic          fall;
    logic          timeout_hit;
    logic [8:0]    measured;

    // ticks lags the true count by one when the final prescale period just completed.
    always_comb begin
      rise        = s & ~s_d;
      fall        = ~s & s_d;
      timeout_hit = (tcnt == TO_LAST) && !rise;
      measured    = (ticks == 9'h1FF) ? 9'h1FF : ticks + {8'd0, presc == PRE_TOP};
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        sync1 <= 1'b0;
        s     <= 1'b0;
        s_d   <= 1'b0;
        state <= ARM;
        warm  <= '0;
        presc <= '0;
        ticks <= '0;
        tcnt  <= '0;
        accel <= LEVEL;
        valid <= 1'b0;
        fault <= 1'b0;
      end else begin
        sync1 <= pwm_raw[g];
        s     <= sync1;
        s_d   <= s;
        valid <= 1'b0;

        // The synchroniser holds reset zeros for two cycles; ARM must not mistake
        // them for a real low level or a pulse in progress would be measured.
        if (warm != 2'd2) warm <= warm + 2'd1;

        if (rise)             tcnt <= '0;
        else if (tcnt != '1)  tcnt <= tcnt + 21'd1;

        if (state == HIGH && fall) begin
          accel <= measured;
          valid <= 1'b1;
          fault <= 1'b0;
          state <= WAIT_RISE;
        end else if (timeout_hit) begin
          accel <= LEVEL;
          valid <= 1'b1;
          fault <= 1'b1;
          state <= ARM;
        end else begin
          case (state)
            ARM: begin
              if (warm == 2'd2 && !s) state <= WAIT_RISE;
            end
            WAIT_RISE: begin
              if (rise) begin
                state <= HIGH;
                presc <= PW'(1);
                ticks <= '0;
              end
            end
            HIGH: begin
              if (s) begin
                if (presc == PRE_TOP) begin
                  presc <= PW'(1);
                  if (ticks != '1) ticks <= ticks + 9'd1;
                end else begin
                  presc <= presc + PW'(1);
                end
              end
            end
            default: state <= ARM;
          endcase
        end
      end
    end
  end

  assign bus.accelX  = g_axis[0].accel;
  assign bus.accelY  = g_axis[1].accel;
  assign bus.valid_x = g_axis[0].valid;
  assign bus.valid_y = g_axis[1].valid;
  assign bus.fault_x = g_axis[0].fault;
  assign bus.fault_y = g_axis[1].fault;

endmodule

// File: doc/accel_pwm_decoder.md
Name: accel_pwm_decoder

Overview:
- Upstream stage of tilt_calculator.
- Converts the two duty-cycle PWM outputs of the MEMS accelerometer (X and Y) into 9-bit unsigned acceleration words.
- Full period maps to 512 counts, so 50% duty (level board, 0g) reads 9'h100; tilt thresholds sit at 9'h1A0 and 9'h0A0.
- Each axis is independent: it synchronises its input, measures high time per pulse, saturates the result, pulses valid, and flags a fault on a dead or stuck sensor.

Parameters:
- PRESCALE, 977: clk cycles per output count. 50 MHz clk with a 100 Hz PWM gives 512 counts per period.
- TIMEOUT_CYCLES, 1500000: clk cycles with no rising edge before fault (30 ms at 50 MHz).
- LEVEL, 9'h100: value forced onto the output on fault and at reset.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- pwm_x  in  1  raw accelerometer X PWM, asynchronous to clk.
- pwm_y  in  1  raw accelerometer Y PWM, asynchronous to clk.
- accelX  out  9  X acceleration word, registered, holds between updates.
- accelY  out  9  Y acceleration word, registered.
- valid_x  out  1  one-cycle strobe on every accelX update.
- valid_y  out  1  one-cycle strobe on every accelY update.
- fault_x  out  1  X sensor timeout flag, level.
- fault_y  out  1  Y sensor timeout flag, level.

Behaviour:
- Reset values:
  - accelX = accelY = LEVEL
  - valid_x = valid_y = 0
  - fault_x = fault_y = 0
  - FSMs go to ARM; all counters clear.
  - Synchroniser flops clear to 0.
- Input conditioning, per axis:
  - 2-flop synchroniser produces s; one more flop produces s_d.
  - rise = s & ~s_d; fall = ~s & s_d.
- FSM, per axis:
  - ARM: wait for s==0, then go to WAIT_RISE. This discards any pulse already in progress at reset release or after a fault.
  - WAIT_RISE: on rise go to HIGH. Load cycle counter = 1, prescale counter = 1, tick count = 0.
  - HIGH, while s==1: cycle counter increments. When the prescale counter reaches PRESCALE it wraps to 1 and tick count increments, saturating at 511.
  - HIGH, on fall: register accel = min(floor(H/PRESCALE), 511), where H = number of cycles s was high. Pulse valid for one cycle, clear fault, go to WAIT_RISE.
- Latency: the output and valid change on the 3rd clk edge after the edge that first samples the pwm fall. A rise is measured with the same offset, so H equals the input high width in clk cycles (±1 for metastability).
- Timeout, per axis:
  - Counter is cleared on rise and on reset, increments otherwise, and saturates.
  - When it reaches TIMEOUT_CYCLES (a single event): fault = 1, accel = LEVEL, valid pulses once, FSM goes to ARM.
  - This covers both stuck-low and stuck-high inputs.
  - fault stays 1 until the next completed measurement.
- Saturation: a pulse of 512·PRESCALE cycles or longer (but shorter than the timeout) yields 511. A pulse shorter than PRESCALE yields 0.
- Simultaneous events:
  - X and Y never interact; both valids may strobe in the same cycle.
  - If fall and timeout hit on the same cycle, the fall measurement wins and fault clears.
- reset asserted mid-pulse: discard the measurement, restore reset values, and re-ARM. No valid strobe is produced for the partial pulse.
- Counter widths: cycle/timeout counter is 21 bits; prescale counter is clog2(PRESCALE)+1 bits; tick count is 9 bits.
- Outputs are never X after reset; there are no combinational paths from inputs to outputs.

Test Plan:
All scenarios run with PRESCALE=4, TIMEOUT_CYCLES=4000.
1. Reset asserted 3 cycles, pwm low -> accelX=accelY=9'h100; valid_*=0; fault_*=0.
2. pwm_x high 40 cycles, low 60 -> accelX=9'h00A; valid_x high exactly 1 cycle, 3 edges after the fall; accelY unchanged.
3. pwm_x high 2100 cycles -> accelX=9'h1FF (saturated); fault_x=0.
4. Reset released while pwm_x high -> first fall produces no valid_x. Next 41-cycle pulse -> accelX=9'h00A.
5. pwm_y low 4000 cycles after last rise -> fault_y=1, accelY=9'h100, one valid_y. Then a 20-cycle pulse -> accelY=9'h005, fault_y=0. Repeat with pwm_y stuck high -> same fault response, no stale value.
6. pwm_x and pwm_y falling in the same cycle, high 24 and 36 cycles respectively -> valid_x and valid_y in the same cycle; accelX=9'h006, accelY=9'h009.
